// File: rtl/audio_pkg.sv
// Shared types and constants for the Direct Sound FIFO controller.
package audio_pkg;

  typedef logic [15:0] sample_t;

  localparam int WR_AW_DEFAULT = 1;

  // Bit positions of the sticky error flags in the sound status register.
  localparam int FLAG_OVF_BIT = 0;
  localparam int FLAG_UDF_BIT = 1;
  localparam int FLAG_W       = 2;

  // FIFO capacity in 16-bit halfwords for a given write address width.
  function automatic int fifo_cap(input int wr_aw);
    return 1 << (wr_aw + 1);
  endfunction

endpackage

// File: rtl/audio_fifo_ctrl_if.sv
// Bus between the FIFO controller and one Audio_SDPB instance:
// 32-bit write port A, 16-bit bypass-mode read port B.
interface audio_fifo_ctrl_if
  import audio_pkg::*;
#(
  parameter int WR_AW = WR_AW_DEFAULT
);

  logic             ram_cea;
  logic [WR_AW-1:0] ram_ada;
  logic [31:0]      ram_din;
  logic             ram_ceb;
  logic             ram_oce;
  logic [WR_AW:0]   ram_adb;
  sample_t          ram_dout;

  modport master (
    output ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb,
    input  ram_dout
  );

  modport slave (
    input  ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb,
    output ram_dout
  );

endinterface

// File: rtl/audio_fifo_ptrs.sv
// Write/read pointers, halfword fill level and push/pop acceptance for
// one circular audio FIFO (words in, halfwords out).
module audio_fifo_ptrs
  import audio_pkg::*;
#(
  parameter int WR_AW = WR_AW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push_req,
  input  logic             pop_req,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             push_drop,
  output logic             pop_empty,
  output logic [WR_AW-1:0] wr_ptr,
  output logic [WR_AW:0]   rd_ptr,
  output logic [WR_AW+1:0] level
);

  localparam int CAP   = fifo_cap(WR_AW);
  localparam int LVL_W = WR_AW + 2;
  localparam logic [LVL_W-1:0] PUSH_MAX = LVL_W'(CAP - 2);

  logic [WR_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [WR_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Both decisions look at the level before this cycle's update, so a
  // full FIFO drops a push even if a pop frees space in the same cycle.
  always_comb begin
    push_ok   = push_req && !clear && (level_q <= PUSH_MAX);
    push_drop = push_req && !clear && (level_q >  PUSH_MAX);
    pop_ok    = pop_req  && !clear && (level_q != '0);
    pop_empty = pop_req  && !clear && (level_q == '0);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + WR_AW'(1);
        level_d  = level_d + LVL_W'(2);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + (WR_AW + 1)'(1);
        level_d  = level_d - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign level  = level_q;

endmodule

// File: rtl/audio_fifo_ctrl.sv
// Direct Sound FIFO sequencer: drives the audio SDPB RAM as a circular
// FIFO, delivers mixer samples, requests DMA refills and flags errors.
module audio_fifo_ctrl
  import audio_pkg::*;
#(
  parameter int WR_AW     = WR_AW_DEFAULT,
  parameter int LOW_WATER = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     fifo_clear,
  input  logic                     sample_tick,
  audio_fifo_ctrl_if.master        ram,
  output sample_t                  sample_out,
  output logic                     sample_valid,
  output logic                     dma_req,
  output logic [WR_AW+1:0]         level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int LVL_W = WR_AW + 2;
  localparam logic [LVL_W-1:0] DMA_TRIP = LVL_W'(LOW_WATER + 1);

  logic             clear;
  logic             push_ok, pop_ok, push_drop, pop_empty;
  logic [WR_AW-1:0] wr_ptr;
  logic [WR_AW:0]   rd_ptr;
  logic [LVL_W-1:0] level_cur;
  logic             capture;

  logic              pop_pend_q, pop_pend_d;
  logic              dma_pend_q, dma_pend_d;
  sample_t           sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              dma_req_q, dma_req_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  assign clear = fifo_clear || reset;

  audio_fifo_ptrs #(
    .WR_AW (WR_AW)
  ) u_ptrs (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push_req  (wr_en),
    .pop_req   (sample_tick),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .push_drop (push_drop),
    .pop_empty (pop_empty),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .level     (level_cur)
  );

  assign ram.ram_cea = push_ok;
  assign ram.ram_ada = wr_ptr;
  assign ram.ram_din = wr_data;
  assign ram.ram_ceb = pop_ok;
  assign ram.ram_oce = 1'b1;
  assign ram.ram_adb = rd_ptr;

  // A pop only crosses the low-water mark downward when it starts one
  // above it with no concurrent push; the level must climb back before
  // that can happen again, which gives the one-shot refill request.
  always_comb begin
    pop_pend_d     = pop_ok;
    dma_pend_d     = pop_ok && !push_ok && (level_cur == DMA_TRIP);
    capture        = pop_pend_q && !clear;
    sample_d       = capture ? ram.ram_dout : sample_q;
    sample_valid_d = capture;
    dma_req_d      = capture && dma_pend_q;

    flags_d = flags_q;
    if (clear) begin
      flags_d = '0;
    end else begin
      if (push_drop) flags_d[FLAG_OVF_BIT] = 1'b1;
      if (pop_empty) flags_d[FLAG_UDF_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_pend_q     <= 1'b0;
      dma_pend_q     <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      dma_req_q      <= 1'b0;
      flags_q        <= '0;
    end else begin
      pop_pend_q     <= pop_pend_d;
      dma_pend_q     <= dma_pend_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      dma_req_q      <= dma_req_d;
      flags_q        <= flags_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign dma_req      = dma_req_q;
  assign level        = level_cur;
  assign overflow     = flags_q[FLAG_OVF_BIT];
  assign underflow    = flags_q[FLAG_UDF_BIT];

endmodule

// File: tb/tb_audio_fifo_ctrl.sv
// Bench for audio_fifo_ctrl: RAM model, queue-based reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_audio_fifo_ctrl;
  import audio_pkg::*;

  localparam int WR_AW     = 1;
  localparam int LOW_WATER = 2;
  localparam int CAP       = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_en;
  logic [31:0]        wr_data;
  logic               fifo_clear;
  logic               sample_tick;
  sample_t            sample_out;
  logic               sample_valid;
  logic               dma_req;
  logic [WR_AW+1:0]   level;
  logic               overflow;
  logic               underflow;

  int vec_count = 0;
  int err_count = 0;

  audio_fifo_ctrl_if #(.WR_AW(WR_AW)) ram_bus ();

  audio_fifo_ctrl #(
    .WR_AW     (WR_AW),
    .LOW_WATER (LOW_WATER)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .fifo_clear   (fifo_clear),
    .sample_tick  (sample_tick),
    .ram          (ram_bus),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .dma_req      (dma_req),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Audio_SDPB stand-in: word writes, halfword reads one cycle after ceb.
  logic [31:0] ram_mem [2**WR_AW];
  sample_t     ram_rd_q;
  assign ram_bus.ram_dout = ram_rd_q;

  initial begin
    ram_rd_q = '0;
    for (int i = 0; i < 2**WR_AW; i++) ram_mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_bus.ram_cea) ram_mem[ram_bus.ram_ada] <= ram_bus.ram_din;
    if (ram_bus.ram_ceb) begin
      if (ram_bus.ram_adb[0]) ram_rd_q <= ram_mem[ram_bus.ram_adb[WR_AW:1]][31:16];
      else                    ram_rd_q <= ram_mem[ram_bus.ram_adb[WR_AW:1]][15:0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: FIFO contents as a halfword queue, one pop in flight.
  sample_t mq[$];
  sample_t m_sample;
  sample_t m_pend_hw;
  bit      m_valid, m_dma, m_ovf, m_udf, m_pend, m_pend_dma;
  bit      model_ready = 1'b0;
  bit      exp_cea, exp_ceb;

  task automatic advanceModel();
    int  pre;
    bit  do_push, do_pop;
    if (reset) begin
      mq.delete();
      m_sample = '0; m_valid = 0; m_dma = 0; m_ovf = 0; m_udf = 0;
      m_pend = 0; m_pend_dma = 0;
      model_ready = 1'b1;
    end else begin
      if (m_pend && !fifo_clear) begin
        m_sample = m_pend_hw; m_valid = 1; m_dma = m_pend_dma;
      end else begin
        m_valid = 0; m_dma = 0;
      end
      m_pend = 0; m_pend_dma = 0;
      if (fifo_clear) begin
        mq.delete();
        m_ovf = 0; m_udf = 0;
      end else begin
        pre     = mq.size();
        do_push = wr_en && (pre <= CAP - 2);
        do_pop  = sample_tick && (pre > 0);
        if (wr_en && !do_push) m_ovf = 1;
        if (sample_tick && !do_pop) m_udf = 1;
        if (do_pop) begin
          m_pend_hw = mq.pop_front();
          m_pend    = 1;
        end
        if (do_push) begin
          mq.push_back(wr_data[15:0]);
          mq.push_back(wr_data[31:16]);
        end
        if (do_pop && pre > LOW_WATER && mq.size() <= LOW_WATER) m_pend_dma = 1;
      end
    end
  endtask

  always begin
    @(negedge clk);
    #3;
    if (model_ready) begin
      exp_cea = !reset && !fifo_clear && wr_en && (mq.size() <= CAP - 2);
      exp_ceb = !reset && !fifo_clear && sample_tick && (mq.size() > 0);
      checkOutput("m_level",        32'(level),            32'(mq.size()));
      checkOutput("m_sample_out",   32'(sample_out),       32'(m_sample));
      checkOutput("m_sample_valid", 32'(sample_valid),     32'(m_valid));
      checkOutput("m_dma_req",      32'(dma_req),          32'(m_dma));
      checkOutput("m_overflow",     32'(overflow),         32'(m_ovf));
      checkOutput("m_underflow",    32'(underflow),        32'(m_udf));
      checkOutput("m_ram_cea",      32'(ram_bus.ram_cea),  32'(exp_cea));
      checkOutput("m_ram_ceb",      32'(ram_bus.ram_ceb),  32'(exp_ceb));
      checkOutput("m_ram_oce",      32'(ram_bus.ram_oce),  32'd1);
      if (exp_cea) checkOutput("m_ram_din", ram_bus.ram_din, wr_data);
    end
    advanceModel();
  end

  task automatic applyStimulus(input logic rst, input logic wr, input logic [31:0] data,
                               input logic clr, input logic tick);
    @(negedge clk);
    reset       = rst;
    wr_en       = wr;
    wr_data     = data;
    fifo_clear  = clr;
    sample_tick = tick;
    #2;
  endtask

  task automatic step(input logic wr, input logic [31:0] data, input logic clr,
                      input logic tick);
    applyStimulus(1'b0, wr, data, clr, tick);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic popAndWait();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; fifo_clear = 1'b0; sample_tick = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("rst_level",     32'(level),        32'd0);
    checkOutput("rst_sample",    32'(sample_out),   32'h0);
    checkOutput("rst_valid",     32'(sample_valid), 32'd0);
    checkOutput("rst_dma",       32'(dma_req),      32'd0);
    checkOutput("rst_flags",     32'({overflow, underflow}), 32'd0);

    // Ordered playback, low half first, 2-cycle pop latency.
    step(1'b1, 32'h2222_1111, 1'b0, 1'b0);
    checkOutput("push1_cea", 32'(ram_bus.ram_cea), 32'd1);
    step(1'b1, 32'h4444_3333, 1'b0, 1'b0);
    checkOutput("push1_level", 32'(level), 32'd2);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("tick1_level", 32'(level), 32'd4);
    checkOutput("tick1_ceb",   32'(ram_bus.ram_ceb), 32'd1);
    idle(1);
    checkOutput("tick1_lvl3",  32'(level), 32'd3);
    checkOutput("tick1_early", 32'(sample_valid), 32'd0);
    idle(1);
    checkOutput("s1_valid", 32'(sample_valid), 32'd1);
    checkOutput("s1_data",  32'(sample_out),   32'h1111);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("s1_pulse", 32'(sample_valid), 32'd0);
    idle(2);
    checkOutput("s2_data",  32'(sample_out), 32'h2222);
    checkOutput("s2_dma",   32'(dma_req),    32'd1);
    checkOutput("s2_level", 32'(level),      32'd2);
    popAndWait();
    checkOutput("s3_data",  32'(sample_out), 32'h3333);
    checkOutput("s3_dma",   32'(dma_req),    32'd0);
    popAndWait();
    checkOutput("s4_data",  32'(sample_out), 32'h4444);
    checkOutput("s4_level", 32'(level),      32'd0);

    // Tick on empty FIFO.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("empty_ceb", 32'(ram_bus.ram_ceb), 32'd0);
    idle(1);
    checkOutput("empty_udf", 32'(underflow), 32'd1);
    idle(1);
    checkOutput("empty_valid", 32'(sample_valid), 32'd0);
    checkOutput("empty_hold",  32'(sample_out),   32'h4444);

    // Push into a full FIFO is dropped.
    step(1'b1, 32'h6666_5555, 1'b0, 1'b0);
    step(1'b1, 32'h8888_7777, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checkOutput("full_level", 32'(level), 32'd4);
    checkOutput("full_cea",   32'(ram_bus.ram_cea), 32'd0);
    idle(1);
    checkOutput("full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) popAndWait();
    checkOutput("full_last", 32'(sample_out), 32'h8888);

    // Simultaneous push and pop around the full boundary.
    step(1'b1, 32'hBBBB_AAAA, 1'b0, 1'b0);
    step(1'b1, 32'hDDDD_CCCC, 1'b0, 1'b0);
    popAndWait();
    step(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    checkOutput("both3_level", 32'(level), 32'd3);
    checkOutput("both3_cea",   32'(ram_bus.ram_cea), 32'd0);
    checkOutput("both3_ceb",   32'(ram_bus.ram_ceb), 32'd1);
    idle(1);
    checkOutput("both3_after", 32'(level), 32'd2);
    idle(1);
    checkOutput("both3_data", 32'(sample_out), 32'hBBBB);
    popAndWait();
    step(1'b1, 32'hFFFF_EEEE, 1'b0, 1'b1);
    checkOutput("both1_cea", 32'(ram_bus.ram_cea), 32'd1);
    checkOutput("both1_ceb", 32'(ram_bus.ram_ceb), 32'd1);
    idle(1);
    checkOutput("both1_level", 32'(level), 32'd2);
    idle(1);
    checkOutput("both1_data", 32'(sample_out), 32'hDDDD);

    // Low-water refill request fires once per downward crossing.
    popAndWait();
    checkOutput("lw_no_2to1", 32'(dma_req), 32'd0);
    step(1'b1, 32'h0202_0101, 1'b0, 1'b0);
    popAndWait();
    checkOutput("lw_3to2",    32'(dma_req),    32'd1);
    checkOutput("lw_3to2_s",  32'(sample_out), 32'hFFFF);
    popAndWait();
    checkOutput("lw_again",   32'(dma_req),    32'd0);
    step(1'b1, 32'h0404_0303, 1'b0, 1'b0);
    popAndWait();
    checkOutput("lw_rearm",   32'(dma_req),    32'd1);
    checkOutput("lw_rearm_s", 32'(sample_out), 32'h0202);

    // Clear cancels a pop in flight and the sticky flags.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);
    checkOutput("clr_level", 32'(level),        32'd0);
    checkOutput("clr_valid", 32'(sample_valid), 32'd0);
    checkOutput("clr_hold",  32'(sample_out),   32'h0202);
    checkOutput("clr_flags", 32'({overflow, underflow}), 32'd0);
    step(1'b1, 32'h0000_0055, 1'b0, 1'b0);
    popAndWait();
    checkOutput("clr_next", 32'(sample_out), 32'h0055);

    // Reset during a pop in flight also zeroes the sample.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("mrst_sample", 32'(sample_out),   32'h0);
    checkOutput("mrst_valid",  32'(sample_valid), 32'd0);
    checkOutput("mrst_level",  32'(level),        32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/audio_fifo_ctrl.md
Name: audio_fifo_ctrl

Overview:
- Sequences one Direct Sound channel's 32-bit-write / 16-bit-read simple dual-port audio RAM as a circular FIFO.
- The CPU/DMA side pushes 32-bit words; the timer-overflow tick pops one 16-bit sample to the mixer.
- Tracks fill level, raises a DMA refill request at low water, and flags overflow/underflow.
- Sits between the APU register file / DMA and the Audio_SDPB instance; one instance per FIFO (A, B).

Parameters:
- WR_AW, 1, RAM write address width (depth = 2**WR_AW 32-bit words); read address width is WR_AW+1
- LOW_WATER, 2, halfword level at or below which dma_req pulses after a pop

Ports:
- clk  in  1  system clock; RAM clka/clkb are driven from it
- reset  in  1  synchronous, active-high
- wr_en  in  1  push request, one word per cycle
- wr_data  in  32  pushed word; [15:0] is the older sample
- fifo_clear  in  1  FIFO reset bit from the sound control register
- sample_tick  in  1  timer overflow, one-cycle pulse
- ram_cea  out  1  RAM write enable
- ram_ada  out  WR_AW  RAM write word address
- ram_din  out  32  RAM write data, equal to wr_data
- ram_ceb  out  1  RAM read enable
- ram_oce  out  1  RAM output clock enable, constant 1
- ram_adb  out  WR_AW+1  RAM read halfword address
- ram_dout  in  16  RAM read data (bypass mode, valid the cycle after ram_ceb)
- sample_out  out  16  current mixer sample, held between pops
- sample_valid  out  1  one-cycle pulse when sample_out updates
- dma_req  out  1  one-cycle refill request
- level  out  WR_AW+2  fill level in halfwords, 0..2**(WR_AW+1)
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a tick found the FIFO empty

Behaviour:
- Reset (synchronous, active-high): wr_ptr=0, rd_ptr=0, level=0, sample_out=0, and sample_valid, dma_req, overflow, underflow, ram_cea, ram_ceb all 0.
- CAP = 2**(WR_AW+1) halfwords.
- Push:
  - Accepted when wr_en=1 and level <= CAP-2.
  - Same cycle: ram_cea=1, ram_ada=wr_ptr.
  - Next edge: wr_ptr increments (wraps mod 2**WR_AW) and level += 2.
  - If wr_en=1 and level > CAP-2: no write, state unchanged, overflow set.
- Pop:
  - On sample_tick with level > 0: ram_ceb=1 and ram_adb=rd_ptr combinationally that cycle (T).
  - Edge T: rd_ptr increments (wraps mod CAP) and level -= 1.
  - Cycle T+1: ram_dout is valid.
  - Edge T+1: sample_out <= ram_dout; sample_valid is high during T+2.
  - Pop latency is 2 cycles from tick to sample_valid.
- Empty tick: no RAM access, sample_out holds its previous value, underflow set, no sample_valid.
- Ordering: halfword address 2k holds word k bits [15:0] and 2k+1 holds bits [31:16], so samples come out low half first.
- Simultaneous push and pop:
  - Both proceed; level changes by +1.
  - Push eligibility uses the pre-pop level, so a push into a full FIFO drops even if a tick arrives the same cycle.
  - No address conflict exists, because a pop only reads filled slots.
- dma_req:
  - One-cycle pulse at edge T+1 of a pop that takes level from above LOW_WATER to <= LOW_WATER.
  - No repeat until level has risen above LOW_WATER again.
- fifo_clear:
  - Has highest priority: wr_ptr, rd_ptr and level go to 0, and overflow/underflow clear.
  - The same cycle's push and pop are ignored (ram_cea=ram_ceb=0).
  - A pop in flight (tick on the previous cycle) is cancelled: sample_out holds its value and there is no sample_valid.
- reset mid-operation behaves as fifo_clear and also zeroes sample_out.
- RAM ports are never enabled outside the cases above.
- level never exceeds CAP and never underflows.

Decomposition:
- Package audio_pkg holds:
  - halfword sample type (16 bit)
  - constant WR_AW_DEFAULT=1
  - CAP derivation function
  - flag bit positions for the status register
- One natural sub-module: audio_fifo_ptrs (wr/rd pointers, level counter, push/pop accept logic).
- Data capture and dma_req edge detect stay in the top level.

Test Plan:
- Reset, push 0x2222_1111 then 0x4444_3333, four ticks spaced by 3 cycles -> sample_out 0x1111, 0x2222, 0x3333, 0x4444; each sample_valid comes 2 cycles after its tick; level goes 4,3,2,1,0.
- Level 4, push 0xDEAD_BEEF -> ram_cea=0, overflow=1, subsequent samples unchanged.
- Level 0, tick -> no ram_ceb, underflow=1, sample_out holds 0x4444, no sample_valid.
- Level 3, wr_en and sample_tick in the same cycle -> push drops (pre-pop level 3 > CAP-2), level=2; at level 1, the same pair gives level=2 with both RAM ports enabled.
- Level 3, tick -> level 2 and dma_req pulses one cycle; a further tick to level 1 gives no second pulse; refill to 3 then pop to 2 -> pulses again.
- Tick followed by fifo_clear the next cycle -> level=0, no sample_valid, flags cleared; a next push of 0x0000_0055 then tick -> sample 0x0055.
